// File: rtl/shift_74hc165.sv
// Reader for a chain of 74HC165 PISO registers: parallel-load, shift in MSB-first, strobe the word.
// Define SHIFT_74HC165_AUTOSCAN_EN for continuous back-to-back frames started automatically after reset.
module shift_74hc165 #(
    parameter int CHAIN = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    input  logic               start,
    input  logic               q7,
    output logic               pl_n,
    output logic               cp,
    output logic [8*CHAIN-1:0] data_out,
    output logic               valid,
    output logic               busy
);

    localparam int BITS = 8 * CHAIN;
    localparam int CW   = $clog2(BITS + 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SAMPLE,
        HIGH
    } state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   count, count_nx;
    logic [BITS-1:0] shreg, shreg_nx;
    logic [BITS-1:0] data_nx;
    logic            pending, pending_nx;
    logic            pl_n_nx, cp_nx, valid_nx, busy_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            shreg    <= '0;
            data_out <= '0;
            pending  <= 1'b0;
            pl_n     <= 1'b1;
            cp       <= 1'b0;
            valid    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nx;
            count    <= count_nx;
            shreg    <= shreg_nx;
            data_out <= data_nx;
            pending  <= pending_nx;
            pl_n     <= pl_n_nx;
            cp       <= cp_nx;
            valid    <= valid_nx;
            busy     <= busy_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        count_nx   = count;
        shreg_nx   = shreg;
        data_nx    = data_out;
        pending_nx = pending;
        pl_n_nx    = pl_n;
        cp_nx      = cp;
        valid_nx   = 1'b0;
        busy_nx    = busy;

        // Request capture runs every clk; the pin sequencer below only advances on ce.
`ifdef SHIFT_74HC165_AUTOSCAN_EN
        if (state == IDLE && !pending) begin
            pending_nx = 1'b1;
            busy_nx    = 1'b1;
        end
`else
        if (start && state == IDLE && !pending) begin
            pending_nx = 1'b1;
            busy_nx    = 1'b1;
        end
`endif

        if (ce) begin
            case (state)
                IDLE: begin
                    if (pending) begin
                        state_nx   = LOAD;
                        pl_n_nx    = 1'b0;
                        pending_nx = 1'b0;
                        count_nx   = '0;
                    end
                end
                LOAD: begin
                    state_nx = SAMPLE;
                    pl_n_nx  = 1'b1;
                end
                SAMPLE: begin
                    // q7 is taken before the rising cp edge shifts the chain.
                    shreg_nx = {shreg[BITS-2:0], q7};
                    count_nx = count + CW'(1);
                    cp_nx    = 1'b1;
                    state_nx = HIGH;
                end
                HIGH: begin
                    cp_nx = 1'b0;
                    if (count == CW'(BITS)) begin
                        data_nx  = shreg;
                        valid_nx = 1'b1;
`ifdef SHIFT_74HC165_AUTOSCAN_EN
                        state_nx = LOAD;
                        pl_n_nx  = 1'b0;
                        count_nx = '0;
`else
                        state_nx = IDLE;
                        busy_nx  = 1'b0;
`endif
                    end else begin
                        state_nx = SAMPLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_74hc165.sv
// Self-checking bench for shift_74hc165: behavioural 74HC165 chain models feed q7,
// expected words and latencies come from the chip's parallel contents and 2+2*BITS.
module tb_shift_74hc165;

    localparam int unsigned NEVER = 1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, ce1, ce2, start1, start2;
    logic        pl1, cp1, valid1, busy1, q71;
    logic        pl2, cp2, valid2, busy2, q72;
    logic [7:0]  data1, par1, chip1;
    logic [15:0] data2, par2, chip2;

    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned div = 0;
    int unsigned cyc = 0;
    int unsigned ce1_mode = 0;

    shift_74hc165 #(.CHAIN(1)) u_dut1 (
        .clk(clk), .rst(rst), .ce(ce1), .start(start1), .q7(q71),
        .pl_n(pl1), .cp(cp1), .data_out(data1), .valid(valid1), .busy(busy1)
    );

    shift_74hc165 #(.CHAIN(2)) u_dut2 (
        .clk(clk), .rst(rst), .ce(ce2), .start(start2), .q7(q72),
        .pl_n(pl2), .cp(cp2), .data_out(data2), .valid(valid2), .busy(busy2)
    );

    // Device models: load while PL is low, shift toward Q7 on rising CP, serial input tied low.
    always @(negedge pl1 or posedge cp1) begin
        if (!pl1) chip1 <= par1;
        else      chip1 <= {chip1[6:0], 1'b0};
    end
    always @(negedge pl2 or posedge cp2) begin
        if (!pl2) chip2 <= par2;
        else      chip2 <= {chip2[14:0], 1'b0};
    end
    assign q71 = chip1[7];
    assign q72 = chip2[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        div++;
        ce2 = (div % 4 == 0);
        if (ce1_mode == 0)          ce1 = 1'b1;
        else if (ce1_mode == NEVER) ce1 = 1'b0;
        else                        ce1 = ($urandom_range(ce1_mode, 0) == 0);
    endtask

    task automatic wait_valid1(input string tag, output int unsigned at);
        int unsigned n = 0;
        tick();
        while (!valid1 && n < 2000) begin
            tick();
            n++;
        end
        check({tag, " valid seen"}, valid1, 1);
        at = cyc;
    endtask

    task automatic run1(input string tag, input logic [7:0] val, input int unsigned mode,
                        input logic [7:0] exp_data, input int unsigned exp_ticks);
        int unsigned ticks = 0, cps = 0, pls = 0, n = 0;
        logic cp_old;
        bit c;
        par1 = val;
        ce1_mode = mode;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check({tag, " busy after start"}, busy1, 1);
        while (!valid1 && n < 2000) begin
            c = ce1;
            cp_old = cp1;
            tick();
            n++;
            if (c) ticks++;
            if (cp1 && !cp_old) cps++;
            if (!pl1) pls++;
        end
        check({tag, " valid"}, valid1, 1);
        check({tag, " data"}, data1, exp_data);
        check({tag, " ce ticks"}, ticks, exp_ticks);
        check({tag, " cp pulses"}, cps, 8);
        if (mode == 0) check({tag, " pl_n low clks"}, pls, 1);
        tick();
        check({tag, " valid one clk"}, valid1, 0);
        check({tag, " busy drop"}, busy1, 0);
    endtask

    typedef struct {
        logic [7:0]  val;
        int unsigned mode;
        logic [7:0]  exp_data;
        int unsigned exp_ticks;
    } vec_t;

    initial begin
        vec_t vecs[6];
        logic [7:0] rv;
        int unsigned rm, n, nvalid, cps, t1, t2, t3;
        int unsigned ticks, run, npulse, hi_min, hi_max, lo_min, lo_max;
        logic old;
        bit c, seen_rise;

        rst = 1'b1; ce1 = 1'b1; ce2 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        par1 = 8'h00; par2 = 16'h0000;

`ifdef SHIFT_74HC165_AUTOSCAN_EN
        par1 = 8'h0F;
        repeat (3) tick();
        rst = 1'b0;
        n = 0;
        while (pl1 && n < 100) begin tick(); n++; end
        check("auto first load", pl1, 0);
        n = 0;
        while (!pl1 && n < 100) begin tick(); n++; end
        par1 = 8'hF0;
        wait_valid1("auto frame1", t1);
        check("auto frame1 data", data1, 8'h0F);
        wait_valid1("auto frame2", t2);
        check("auto frame2 data", data1, 8'hF0);
        wait_valid1("auto frame3", t3);
        check("auto period stable", t3 - t2, t2 - t1);
        check("auto busy held", busy1, 1);
`else
        vecs = '{
            '{8'hA5, 0, 8'hA5, 18},
            '{8'h00, 0, 8'h00, 18},
            '{8'hFF, 0, 8'hFF, 18},
            '{8'h80, 0, 8'h80, 18},
            '{8'h01, 3, 8'h01, 18},
            '{8'h5A, 2, 8'h5A, 18}
        };

        // Reset held three clocks, with a start request that must be lost.
        start1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("reset outputs", {pl1, cp1, valid1, busy1, data1}, {4'b1000, 8'h00});
        end
        rst = 1'b0;
        start1 = 1'b0;
        repeat (4) tick();
        check("start lost in reset", {busy1, pl1}, 2'b01);

        for (int i = 0; i < 6; i++)
            run1($sformatf("vec%0d", i), vecs[i].val, vecs[i].mode, vecs[i].exp_data, vecs[i].exp_ticks);

        for (int i = 0; i < 6; i++) begin
            rv = 8'($urandom);
            rm = $urandom_range(3, 0);
            run1($sformatf("rand%0d", i), rv, rm, rv, 2 + 2 * 8);
        end

        // Start while busy is ignored, not queued.
        ce1_mode = 0;
        par1 = 8'h3C;
        start1 = 1'b1; tick(); start1 = 1'b0;
        repeat (5) tick();
        start1 = 1'b1; tick(); start1 = 1'b0;
        nvalid = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (valid1) begin
                nvalid++;
                check("ignored start data", data1, 8'h3C);
            end
        end
        check("ignored start valids", nvalid, 1);
        check("ignored start busy", busy1, 0);

        // Reset after the third cp pulse abandons the frame.
        par1 = 8'h96;
        start1 = 1'b1; tick(); start1 = 1'b0;
        cps = 0;
        n = 0;
        while (cps < 3 && n < 200) begin
            old = cp1;
            tick();
            n++;
            if (cp1 && !old) cps++;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid rst pins", {pl1, cp1, valid1, busy1}, 4'b1000);
        check("mid rst data", data1, 8'h00);
        run1("after rst", 8'h69, 0, 8'h69, 18);

        // With ce held low the request waits and the pins stay idle.
        par1 = 8'hC3;
        ce1_mode = NEVER;
        start1 = 1'b1; tick(); start1 = 1'b0;
        repeat (10) tick();
        check("frozen pins", {busy1, pl1, cp1}, 3'b110);
        ce1_mode = 0;
        wait_valid1("unfrozen", t1);
        check("unfrozen data", data1, 8'hC3);

        // Two-device chain, ce every 4th clk.
        par2 = 16'h1234;
        start2 = 1'b1; tick(); start2 = 1'b0;
        ticks = 0; run = 0; npulse = 0; n = 0; seen_rise = 0;
        hi_min = 999; hi_max = 0; lo_min = 999; lo_max = 0;
        while (!valid2 && n < 2000) begin
            c = ce2;
            old = cp2;
            tick();
            n++;
            run++;
            if (c) ticks++;
            if (cp2 !== old) begin
                if (old) begin
                    if (run < hi_min) hi_min = run;
                    if (run > hi_max) hi_max = run;
                end else if (seen_rise) begin
                    if (run < lo_min) lo_min = run;
                    if (run > lo_max) lo_max = run;
                end
                if (cp2) begin
                    seen_rise = 1;
                    npulse++;
                end
                run = 0;
            end
        end
        check("chain2 valid", valid2, 1);
        check("chain2 data", data2, 16'h1234);
        check("chain2 ce ticks", ticks, 34);
        check("chain2 pulses", npulse, 16);
        check("chain2 cp high", {hi_min, hi_max}, {32'd4, 32'd4});
        check("chain2 cp low", {lo_min, lo_max}, {32'd4, 32'd4});
        tick();
        check("chain2 busy drop", {valid2, busy2}, 2'b00);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
